// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, sequencer states, span/legality helpers.
// Pure declarations; no latency or backpressure of its own.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_DONE
    } lsu_state_t;

    // Only the low two funct3 bits carry the access size; bit 2 is the unsigned flag.
    function automatic logic span_detect(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return (off == 2'b11);
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_seq_if.sv
// Request, memory and response signals of the LSU memory sequencer.
// slave = sequencer side, master = requester/memory side.
interface lsu_mem_seq_if #(
    parameter int ADDR_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [2:0]        i_req_funct3;
    logic [ADDR_W-1:0] i_req_addr;
    logic [31:0]       i_req_wdata;

    logic              o_mem_valid;
    logic              i_mem_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [3:0]        o_mem_be;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_rvalid;
    logic [31:0]       i_mem_rdata;

    logic              o_rsp_valid;
    logic [31:0]       o_data1;
    logic [31:0]       o_data2;
    logic [2:0]        o_funct3;
    logic [1:0]        o_lsu_addr;
    logic              o_err;

    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_req_ready,
        output o_mem_valid, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
        output o_rsp_valid, o_data1, o_data2, o_funct3, o_lsu_addr, o_err
    );

    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_req_ready,
        input  o_mem_valid, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
        input  o_rsp_valid, o_data1, o_data2, o_funct3, o_lsu_addr, o_err
    );
endinterface

// File: rtl/lsu_store_align.sv
// Store lane alignment: byte enables and data for the first and overflow word.
// Combinational, zero latency; no backpressure.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1
);
    logic [63:0] data_sh;
    logic [7:0]  be_sh;

    // Shift across a double-word so the bytes pushed past lane 3 land in word1.
    always_comb begin
        data_sh = {32'b0, wdata} << {off, 3'b000};
        be_sh   = {4'b0, base_mask(size)} << off;
    end

    assign wdata0 = data_sh[31:0];
    assign wdata1 = data_sh[63:32];
    assign be0    = be_sh[3:0];
    assign be1    = be_sh[7:4];

endmodule

// File: rtl/lsu_mem_seq.sv
// Splits a byte-addressed load/store into one or two word accesses and returns raw words.
// Latency: mem request 1 cycle after accept, rsp 1 cycle after last beat; ready only in IDLE, rsp has no backpressure.
module lsu_mem_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lsu_mem_seq_if.slave  bus
);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    lsu_state_t        state;
    logic              we_q;
    logic              span_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [3:0]        be1_q;
    logic [31:0]       wd1_q;

    logic [ADDR_W-1:0] word0;
    logic [3:0]        al_be0, al_be1;
    logic [31:0]       al_wd0, al_wd1;

    assign word0 = {bus.i_req_addr[ADDR_W-1:2], 2'b00};

    lsu_store_align u_align (
        .size   (bus.i_req_funct3[1:0]),
        .off    (bus.i_req_addr[1:0]),
        .wdata  (bus.i_req_wdata),
        .be0    (al_be0),
        .be1    (al_be1),
        .wdata0 (al_wd0),
        .wdata1 (al_wd1)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            we_q            <= 1'b0;
            span_q          <= 1'b0;
            addr1_q         <= '0;
            be1_q           <= '0;
            wd1_q           <= '0;
            bus.o_req_ready <= 1'b1;
            bus.o_mem_valid <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_be    <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_rsp_valid <= 1'b0;
            bus.o_data1     <= '0;
            bus.o_data2     <= '0;
            bus.o_funct3    <= '0;
            bus.o_lsu_addr  <= '0;
            bus.o_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_req_valid) begin
                        bus.o_req_ready <= 1'b0;
                        bus.o_funct3    <= bus.i_req_funct3;
                        bus.o_lsu_addr  <= bus.i_req_addr[1:0];
                        bus.o_data1     <= '0;
                        bus.o_data2     <= '0;
                        we_q            <= bus.i_req_we;
                        span_q          <= span_detect(bus.i_req_funct3[1:0], bus.i_req_addr[1:0]);
                        addr1_q         <= word0 + WORD_STEP;
                        be1_q           <= bus.i_req_we ? al_be1 : 4'hF;
                        wd1_q           <= bus.i_req_we ? al_wd1 : 32'h0;
                        if (!f3_legal(bus.i_req_we, bus.i_req_funct3)) begin
                            bus.o_err       <= 1'b1;
                            bus.o_rsp_valid <= 1'b1;
                            state           <= ST_DONE;
                        end else begin
                            bus.o_err       <= 1'b0;
                            bus.o_mem_valid <= 1'b1;
                            bus.o_mem_addr  <= word0;
                            bus.o_mem_we    <= bus.i_req_we;
                            bus.o_mem_be    <= bus.i_req_we ? al_be0 : 4'hF;
                            bus.o_mem_wdata <= bus.i_req_we ? al_wd0 : 32'h0;
                            state           <= ST_REQ0;
                        end
                    end
                end
                ST_REQ0: begin
                    if (bus.i_mem_ready) begin
                        if (!we_q) begin
                            bus.o_mem_valid <= 1'b0;
                            state           <= ST_WAIT0;
                        end else if (span_q) begin
                            bus.o_mem_addr  <= addr1_q;
                            bus.o_mem_be    <= be1_q;
                            bus.o_mem_wdata <= wd1_q;
                            state           <= ST_REQ1;
                        end else begin
                            bus.o_mem_valid <= 1'b0;
                            bus.o_rsp_valid <= 1'b1;
                            state           <= ST_DONE;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (bus.i_mem_rvalid) begin
                        bus.o_data1 <= bus.i_mem_rdata;
                        if (span_q) begin
                            bus.o_mem_valid <= 1'b1;
                            bus.o_mem_addr  <= addr1_q;
                            bus.o_mem_be    <= be1_q;
                            bus.o_mem_wdata <= wd1_q;
                            state           <= ST_REQ1;
                        end else begin
                            bus.o_rsp_valid <= 1'b1;
                            state           <= ST_DONE;
                        end
                    end
                end
                ST_REQ1: begin
                    if (bus.i_mem_ready) begin
                        bus.o_mem_valid <= 1'b0;
                        if (we_q) begin
                            bus.o_rsp_valid <= 1'b1;
                            state           <= ST_DONE;
                        end else begin
                            state <= ST_WAIT1;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (bus.i_mem_rvalid) begin
                        bus.o_data2     <= bus.i_mem_rdata;
                        bus.o_rsp_valid <= 1'b1;
                        state           <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.o_rsp_valid <= 1'b0;
                    bus.o_req_ready <= 1'b1;
                    state           <= ST_IDLE;
                end
                default: begin
                    bus.o_mem_valid <= 1'b0;
                    bus.o_rsp_valid <= 1'b0;
                    bus.o_req_ready <= 1'b1;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_seq.sv
// Directed bench for lsu_mem_seq: cycle-exact memory handshakes and responses.
module tb_lsu_mem_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    lsu_mem_seq_if #(.ADDR_W(32)) bus ();

    lsu_mem_seq #(.ADDR_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns in the cycle after acceptance.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
        chk("req_ready", {63'b0, bus.o_req_ready}, 64'd1);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wdata;
        step();
        bus.i_req_valid  = 1'b0;
        chk("ready_busy", {63'b0, bus.o_req_ready}, 64'd0);
    endtask

    // Expects a memory request this cycle, holds ready low for 'stall' cycles, then accepts it.
    task automatic expect_mem(input string tag, input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wdata, input int stall);
        for (int i = 0; i <= stall; i++) begin
            bus.i_mem_ready = (i == stall);
            chk({tag, "_valid"}, {63'b0, bus.o_mem_valid}, 64'd1);
            chk({tag, "_addr"},  {32'b0, bus.o_mem_addr},  {32'b0, addr});
            chk({tag, "_we"},    {63'b0, bus.o_mem_we},    {63'b0, we});
            chk({tag, "_be"},    {60'b0, bus.o_mem_be},    {60'b0, be});
            chk({tag, "_wdata"}, {32'b0, bus.o_mem_wdata}, {32'b0, wdata});
            step();
        end
        bus.i_mem_ready = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] data);
        chk({tag, "_idle_bus"}, {63'b0, bus.o_mem_valid}, 64'd0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = data;
        step();
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                              input logic err, input logic [2:0] f3, input logic [1:0] la);
        chk({tag, "_rsp"},   {63'b0, bus.o_rsp_valid}, 64'd1);
        chk({tag, "_data1"}, {32'b0, bus.o_data1},     {32'b0, d1});
        chk({tag, "_data2"}, {32'b0, bus.o_data2},     {32'b0, d2});
        chk({tag, "_err"},   {63'b0, bus.o_err},       {63'b0, err});
        chk({tag, "_f3"},    {61'b0, bus.o_funct3},    {61'b0, f3});
        chk({tag, "_la"},    {62'b0, bus.o_lsu_addr},  {62'b0, la});
        step();
        chk({tag, "_rsp_end"}, {63'b0, bus.o_rsp_valid}, 64'd0);
        chk({tag, "_ready"},   {63'b0, bus.o_req_ready}, 64'd1);
    endtask

    initial begin
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_funct3 = 3'b0;
        bus.i_req_addr   = 32'h0;
        bus.i_req_wdata  = 32'h0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'h0;

        step();
        step();
        chk("rst_ready", {63'b0, bus.o_req_ready}, 64'd1);
        chk("rst_mv",    {63'b0, bus.o_mem_valid}, 64'd0);
        chk("rst_rsp",   {63'b0, bus.o_rsp_valid}, 64'd0);
        chk("rst_d1",    {32'b0, bus.o_data1},     64'd0);
        chk("rst_err",   {63'b0, bus.o_err},       64'd0);
        rst = 1'b0;
        step();

        // Aligned LW: mem request at T+1, rsp at T+3.
        send(1'b0, 3'b010, 32'h100, 32'h0);
        expect_mem("lw_al", 32'h100, 1'b0, 4'hF, 32'h0, 0);
        rd("lw_al", 32'hDEADBEEF);
        expect_rsp("lw_al", 32'hDEADBEEF, 32'h0, 1'b0, 3'b010, 2'd3 - 2'd3);

        // Spanning LW at offset 3.
        send(1'b0, 3'b010, 32'h103, 32'h0);
        expect_mem("lw_sp0", 32'h100, 1'b0, 4'hF, 32'h0, 0);
        rd("lw_sp0", 32'h44332211);
        expect_mem("lw_sp1", 32'h104, 1'b0, 4'hF, 32'h0, 0);
        rd("lw_sp1", 32'h88776655);
        expect_rsp("lw_sp", 32'h44332211, 32'h88776655, 1'b0, 3'b010, 2'd3);

        // Spanning SW at offset 1.
        send(1'b1, 3'b010, 32'h101, 32'h11223344);
        expect_mem("sw_sp0", 32'h100, 1'b1, 4'b1110, 32'h22334400, 0);
        expect_mem("sw_sp1", 32'h104, 1'b1, 4'b0001, 32'h00000011, 0);
        expect_rsp("sw_sp", 32'h0, 32'h0, 1'b0, 3'b010, 2'd1);

        // SH at offset 2 stays in one word.
        send(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
        expect_mem("sh_al", 32'h100, 1'b1, 4'b1100, 32'hABCD0000, 0);
        expect_rsp("sh_al", 32'h0, 32'h0, 1'b0, 3'b001, 2'd2);

        // Second word wraps to address zero.
        send(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        expect_mem("lw_wr0", 32'hFFFFFFFC, 1'b0, 4'hF, 32'h0, 0);
        rd("lw_wr0", 32'hA5A5A5A5);
        expect_mem("lw_wr1", 32'h00000000, 1'b0, 4'hF, 32'h0, 0);
        rd("lw_wr1", 32'h5A5A5A5A);
        expect_rsp("lw_wr", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 3'b010, 2'd2);

        // LB with memory stalling three cycles.
        send(1'b0, 3'b000, 32'h205, 32'h0);
        expect_mem("lb_st", 32'h204, 1'b0, 4'hF, 32'h0, 3);
        rd("lb_st", 32'h0000AB00);
        expect_rsp("lb_st", 32'h0000AB00, 32'h0, 1'b0, 3'b000, 2'd1);

        // SB in the top lane.
        send(1'b1, 3'b000, 32'h203, 32'h0000005A);
        expect_mem("sb_3", 32'h200, 1'b1, 4'b1000, 32'h5A000000, 0);
        expect_rsp("sb_3", 32'h0, 32'h0, 1'b0, 3'b000, 2'd3);

        // Spanning LHU.
        send(1'b0, 3'b101, 32'h0FF, 32'h0);
        expect_mem("lhu_sp0", 32'h0FC, 1'b0, 4'hF, 32'h0, 0);
        rd("lhu_sp0", 32'h11000000);
        expect_mem("lhu_sp1", 32'h100, 1'b0, 4'hF, 32'h0, 0);
        rd("lhu_sp1", 32'h00000022);
        expect_rsp("lhu_sp", 32'h11000000, 32'h00000022, 1'b0, 3'b101, 2'd3);

        // Illegal load funct3: no memory access, error rsp at T+1, data cleared.
        send(1'b0, 3'b011, 32'h102, 32'h0);
        chk("ill_ld_mv", {63'b0, bus.o_mem_valid}, 64'd0);
        expect_rsp("ill_ld", 32'h0, 32'h0, 1'b1, 3'b011, 2'd2);

        // Illegal store funct3.
        send(1'b1, 3'b100, 32'h041, 32'hFFFFFFFF);
        chk("ill_st_mv", {63'b0, bus.o_mem_valid}, 64'd0);
        expect_rsp("ill_st", 32'h0, 32'h0, 1'b1, 3'b100, 2'd1);

        // Spanning SH at offset 3.
        send(1'b1, 3'b001, 32'h303, 32'h00001234);
        expect_mem("sh_sp0", 32'h300, 1'b1, 4'b1000, 32'h34000000, 0);
        expect_mem("sh_sp1", 32'h304, 1'b1, 4'b0001, 32'h00000012, 0);
        expect_rsp("sh_sp", 32'h0, 32'h0, 1'b0, 3'b001, 2'd3);

        // Reset while waiting for the second read; late rvalid must be ignored.
        send(1'b0, 3'b010, 32'h402, 32'h0);
        expect_mem("rst_mid0", 32'h400, 1'b0, 4'hF, 32'h0, 0);
        rd("rst_mid0", 32'h13579BDF);
        expect_mem("rst_mid1", 32'h404, 1'b0, 4'hF, 32'h0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_mv",    {63'b0, bus.o_mem_valid}, 64'd0);
        chk("rst_mid_ready", {63'b0, bus.o_req_ready}, 64'd1);
        chk("rst_mid_rsp",   {63'b0, bus.o_rsp_valid}, 64'd0);
        chk("rst_mid_d1",    {32'b0, bus.o_data1},     64'd0);
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h99999999;
        step();
        bus.i_mem_rvalid = 1'b0;
        chk("late_rv_rsp", {63'b0, bus.o_rsp_valid}, 64'd0);
        chk("late_rv_d2",  {32'b0, bus.o_data2},     64'd0);
        step();
        chk("late_rv_rsp2", {63'b0, bus.o_rsp_valid}, 64'd0);

        // Normal operation resumes, error flag cleared.
        send(1'b0, 3'b010, 32'h008, 32'h0);
        expect_mem("lw_rec", 32'h008, 1'b0, 4'hF, 32'h0, 0);
        rd("lw_rec", 32'hCAFEF00D);
        expect_rsp("lw_rec", 32'hCAFEF00D, 32'h0, 1'b0, 3'b010, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
